datapath_unit: RTL and testbench
================================

Name: datapath_unit

Overview:
Processor datapath that executes the control signals issued by the control-unit state machine each cycle. It contains a 16x16 register file, an 8-function ALU, a 256x16 synchronous data memory, and the RF write-data mux. It is the responder side of the control-signal interface. Load is two-phase because the memory read has one-cycle latency: the first cycle presents the address, the second writes the result back.

Parameters:
DATA_W, 16, datapath word width
RF_AW, 4, register file address width (2^RF_AW registers)
DM_AW, 8, data memory address width (2^DM_AW words)

Ports:
Clk  input  1  clock, all state updates on rising edge
ResetN  input  1  synchronous active-low reset
D_addr  input  DM_AW  data memory address
D_wr  input  1  data memory write enable
RF_s  input  1  RF write-data select: 1 = Mem_q, 0 = ALU_out
RF_W_en  input  1  RF write enable
RF_W_addr  input  RF_AW  RF write address
RF_Ra_addr  input  RF_AW  RF A-port read address
RF_Rb_addr  input  RF_AW  RF B-port read address
Alu_s0  input  3  ALU function select
Ra_data  output  DATA_W  RF A-port read data (combinational)
Rb_data  output  DATA_W  RF B-port read data (combinational)
ALU_out  output  DATA_W  ALU result (combinational)
ALU_zero  output  1  high when ALU_out == 0
Mem_q  output  DATA_W  registered data memory read data

Behaviour:
- Reset: ResetN is synchronous and active-low; clock is Clk.
  - When ResetN is low at a rising edge, all RF registers are set to 0 and Mem_q is set to 0.
  - D_wr and RF_W_en are ignored in that cycle.
  - Data memory contents are not altered by reset. Memory is zero-initialised at elaboration.
- Reset outputs: after reset, Ra_data = Rb_data = 0 and Mem_q = 0. ALU_out and ALU_zero follow the combinational definition (with zero operands, ALU_out = 0 and ALU_zero = 1 for functions 0–6; function 7 gives ALU_out = 1).
- RF reads: asynchronous.
  - Ra_data = RF[RF_Ra_addr]; Rb_data = RF[RF_Rb_addr].
  - Read of an address being written in the same cycle returns the old value. The new value is visible after the edge.
- RF write: on a rising edge with ResetN = 1 and RF_W_en = 1, RF[RF_W_addr] <= (RF_s ? Mem_q : ALU_out).
  - R0 is an ordinary writable register; it is not hardwired to zero.
- ALU functions, with A = Ra_data and B = Rb_data; all arithmetic is modulo 2^DATA_W with no carry or overflow output:
  - 0: output 0
  - 1: A+B
  - 2: A-B
  - 3: pass A
  - 4: A^B
  - 5: A|B
  - 6: A&B
  - 7: A+1
- Data memory write: on a rising edge with ResetN = 1 and D_wr = 1, DM[D_addr] <= Ra_data.
- Data memory read: every rising edge with ResetN = 1, Mem_q <= DM[D_addr], i.e. one-cycle latency.
  - Read-during-write to the same address returns the old word; the new word appears on the following cycle.
- Load timing:
  - Cycle N (Load_A): D_addr is presented.
  - Edge N: Mem_q is captured.
  - Cycle N+1 (Load_B): D_addr held, RF_s = 1, RF_W_en = 1.
  - Edge N+1: the RF is written with the word at D_addr.
- Store timing: D_addr, D_wr and RF_Ra_addr are presented in one cycle; memory is written at that edge.
- Add/Sub timing: single cycle. Operands, Alu_s0, RF_W_en and RF_s = 0 are presented together; the result is written at the edge.
- Simultaneous events: D_wr and RF_W_en may both be high in one cycle, and both writes occur. The memory write uses the pre-edge Ra_data.
- Address wrap: addresses are exact-width and have no out-of-range case.
- X-safety: Alu_s0 is a full 3-bit decode, so no latch is inferred. There are no internal state machines; all sequencing is owned by the control unit.

Test Plan:
1. Drive ResetN=0 for 2 edges with D_wr=1 and RF_W_en=1 at RF_W_addr=3 → every RF register reads 0, Mem_q=0, and DM[D_addr] is unchanged after release.
2. After reset, Alu_s0=7, Ra=R0, RF_W_en=1, RF_W_addr=1 → R1=0x0001. Then Alu_s0=1 with Ra=R1, Rb=R1, RF_W_addr=2 → R2=0x0002.
3. Alu_s0=2 with Ra=R0 (0), Rb=R1 (1), write R4 → R4=0xFFFF and ALU_zero=0 during the op. Then Alu_s0=1 with Ra=R4, Rb=R1 → ALU_out=0x0000, ALU_zero=1.
4. Store with D_addr=0x2A, D_wr=1, Ra=R4 (0xFFFF). Then Load_A with D_addr=0x2A, then Load_B with RF_s=1, RF_W_en=1, RF_W_addr=5 → Mem_q=0xFFFF after Load_A and R5=0xFFFF after Load_B.
5. Read-during-write at D_addr=0x10: DM[0x10]=0x0002 beforehand, then store R4 (0xFFFF) at 0x10 in the same cycle → Mem_q=0x0002 after that edge and 0xFFFF one edge later.
6. RF_W_en=1 writing R1 while Ra=R1, Alu_s0=7 → Ra_data shows the old value 0x0001 before the edge and R1=0x0002 after it. Assert ResetN=0 during an in-progress Load_B → R5 is not written and all registers read 0.

Source files
------------

// File: rtl/datapath_unit.sv
// Processor datapath: 16-entry register file, 8-function ALU, synchronous data
// memory with registered read port, and the RF write-data mux.
module datapath_unit #(
   parameter int DATA_W = 16,
   parameter int RF_AW  = 4,
   parameter int DM_AW  = 8
) (
   input  logic              Clk,
   input  logic              ResetN,
   input  logic [DM_AW-1:0]  D_addr,
   input  logic              D_wr,
   input  logic              RF_s,
   input  logic              RF_W_en,
   input  logic [RF_AW-1:0]  RF_W_addr,
   input  logic [RF_AW-1:0]  RF_Ra_addr,
   input  logic [RF_AW-1:0]  RF_Rb_addr,
   input  logic [2:0]        Alu_s0,
   output logic [DATA_W-1:0] Ra_data,
   output logic [DATA_W-1:0] Rb_data,
   output logic [DATA_W-1:0] ALU_out,
   output logic              ALU_zero,
   output logic [DATA_W-1:0] Mem_q
);

   localparam int RF_N = 1 << RF_AW;
   localparam int DM_N = 1 << DM_AW;

   logic [DATA_W-1:0] rf_q [RF_N];
   logic [DATA_W-1:0] rf_d [RF_N];
   logic [DATA_W-1:0] mem_q_q;
   logic [DATA_W-1:0] mem_q_d;
   logic [DATA_W-1:0] rf_wr_data;
   logic [DATA_W-1:0] alu_out;

   // Memory contents survive reset; they start at zero only at elaboration.
   logic [DATA_W-1:0] dm_mem [DM_N] = '{default: '0};

   assign Ra_data = rf_q[RF_Ra_addr];
   assign Rb_data = rf_q[RF_Rb_addr];

   always_comb begin
      alu_out = '0;
      case (Alu_s0)
         3'd0: alu_out = '0;
         3'd1: alu_out = Ra_data + Rb_data;
         3'd2: alu_out = Ra_data - Rb_data;
         3'd3: alu_out = Ra_data;
         3'd4: alu_out = Ra_data ^ Rb_data;
         3'd5: alu_out = Ra_data | Rb_data;
         3'd6: alu_out = Ra_data & Rb_data;
         3'd7: alu_out = Ra_data + DATA_W'(1);
      endcase
   end

   assign ALU_out  = alu_out;
   assign ALU_zero = (alu_out == '0);

   assign rf_wr_data = RF_s ? mem_q_q : alu_out;

   always_comb begin
      rf_d = rf_q;
      if (!ResetN) begin
         for (int i = 0; i < RF_N; i++) rf_d[i] = '0;
      end else if (RF_W_en) begin
         rf_d[RF_W_addr] = rf_wr_data;
      end
   end

   always_comb begin
      mem_q_d = '0;
      if (ResetN) mem_q_d = dm_mem[D_addr];
   end

   always_ff @(posedge Clk) begin
      rf_q    <= rf_d;
      mem_q_q <= mem_q_d;
   end

   // Store uses the pre-edge A-port value, so a same-cycle RF write cannot leak in.
   always_ff @(posedge Clk) begin
      if (ResetN && D_wr) dm_mem[D_addr] <= Ra_data;
   end

   assign Mem_q = mem_q_q;

endmodule

// File: tb/tb_datapath_unit.sv
// Directed self-checking bench for datapath_unit: reset, ALU ops, load/store
// timing, read-during-write and reset during an in-flight load.
module tb_datapath_unit;

   logic        Clk;
   logic        ResetN;
   logic [7:0]  D_addr;
   logic        D_wr;
   logic        RF_s;
   logic        RF_W_en;
   logic [3:0]  RF_W_addr;
   logic [3:0]  RF_Ra_addr;
   logic [3:0]  RF_Rb_addr;
   logic [2:0]  Alu_s0;
   logic [15:0] Ra_data;
   logic [15:0] Rb_data;
   logic [15:0] ALU_out;
   logic        ALU_zero;
   logic [15:0] Mem_q;

   int n_cmp = 0;
   int n_err = 0;

   datapath_unit dut (
      .Clk        (Clk),
      .ResetN     (ResetN),
      .D_addr     (D_addr),
      .D_wr       (D_wr),
      .RF_s       (RF_s),
      .RF_W_en    (RF_W_en),
      .RF_W_addr  (RF_W_addr),
      .RF_Ra_addr (RF_Ra_addr),
      .RF_Rb_addr (RF_Rb_addr),
      .Alu_s0     (Alu_s0),
      .Ra_data    (Ra_data),
      .Rb_data    (Rb_data),
      .ALU_out    (ALU_out),
      .ALU_zero   (ALU_zero),
      .Mem_q      (Mem_q)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic idle();
      D_wr = 1'b0; RF_W_en = 1'b0; RF_s = 1'b0; Alu_s0 = 3'd0;
   endtask

   task automatic test_reset();
      idle();
      ResetN = 1'b0; D_addr = 8'h33; RF_Ra_addr = 4'd0; RF_Rb_addr = 4'd0; RF_W_addr = 4'd0;
      step(); step();
      ResetN = 1'b1;
      // R1 = R0 + 1, then store R1 (1) at 0x33
      Alu_s0 = 3'd7; RF_W_en = 1'b1; RF_W_addr = 4'd1;
      step();
      idle(); RF_Ra_addr = 4'd1; D_addr = 8'h33; D_wr = 1'b1;
      step();
      // reset with both write enables active; R0 = 0 would overwrite DM[0x33]
      ResetN = 1'b0; D_wr = 1'b1; RF_W_en = 1'b1; RF_W_addr = 4'd3; Alu_s0 = 3'd7;
      RF_Ra_addr = 4'd0; D_addr = 8'h33;
      step(); step();
      n_cmp++;
      if (Mem_q !== 16'h0000) begin
         n_err++; $display("FAIL reset_mem_q: got %h expected 0000", Mem_q);
      end
      for (int i = 0; i < 16; i++) begin
         RF_Ra_addr = 4'(i); RF_Rb_addr = 4'(15 - i);
         #1;
         n_cmp++;
         if (Ra_data !== 16'h0000 || Rb_data !== 16'h0000) begin
            n_err++; $display("FAIL reset_rf[%0d]: got a=%h b=%h expected 0000", i, Ra_data, Rb_data);
         end
      end
      RF_Ra_addr = 4'd0; Alu_s0 = 3'd0;
      #1;
      n_cmp++;
      if (ALU_out !== 16'h0000 || ALU_zero !== 1'b1) begin
         n_err++; $display("FAIL reset_alu: got %h z=%b expected 0000 z=1", ALU_out, ALU_zero);
      end
      ResetN = 1'b1; idle(); D_addr = 8'h33;
      step();
      n_cmp++;
      if (Mem_q !== 16'h0001) begin
         n_err++; $display("FAIL reset_dm_kept: got %h expected 0001", Mem_q);
      end
   endtask

   task automatic test_add_inc();
      idle(); Alu_s0 = 3'd7; RF_Ra_addr = 4'd0; RF_W_en = 1'b1; RF_W_addr = 4'd1;
      #1;
      n_cmp++;
      if (ALU_out !== 16'h0001) begin
         n_err++; $display("FAIL inc_alu: got %h expected 0001", ALU_out);
      end
      step();
      Alu_s0 = 3'd1; RF_Ra_addr = 4'd1; RF_Rb_addr = 4'd1; RF_W_addr = 4'd2;
      #1;
      n_cmp++;
      if (Ra_data !== 16'h0001) begin
         n_err++; $display("FAIL inc_r1: got %h expected 0001", Ra_data);
      end
      step();
      idle(); RF_Ra_addr = 4'd2;
      #1;
      n_cmp++;
      if (Ra_data !== 16'h0002) begin
         n_err++; $display("FAIL add_r2: got %h expected 0002", Ra_data);
      end
   endtask

   task automatic test_sub_zero();
      logic [15:0] exp_out [8];
      idle(); Alu_s0 = 3'd2; RF_Ra_addr = 4'd0; RF_Rb_addr = 4'd1; RF_W_en = 1'b1; RF_W_addr = 4'd4;
      #1;
      n_cmp++;
      if (ALU_out !== 16'hFFFF || ALU_zero !== 1'b0) begin
         n_err++; $display("FAIL sub_alu: got %h z=%b expected ffff z=0", ALU_out, ALU_zero);
      end
      step();
      idle(); Alu_s0 = 3'd1; RF_Ra_addr = 4'd4; RF_Rb_addr = 4'd1;
      #1;
      n_cmp++;
      if (ALU_out !== 16'h0000 || ALU_zero !== 1'b1) begin
         n_err++; $display("FAIL wrap_add: got %h z=%b expected 0000 z=1", ALU_out, ALU_zero);
      end
      // A = R4 (ffff), B = R2 (0002) across every function
      exp_out = '{16'h0000, 16'h0001, 16'hFFFD, 16'hFFFF, 16'hFFFD, 16'hFFFF, 16'h0002, 16'h0000};
      RF_Rb_addr = 4'd2;
      for (int f = 0; f < 8; f++) begin
         Alu_s0 = 3'(f);
         #1;
         n_cmp++;
         if (ALU_out !== exp_out[f] || ALU_zero !== (exp_out[f] == 16'h0000)) begin
            n_err++; $display("FAIL alu_fn%0d: got %h z=%b expected %h", f, ALU_out, ALU_zero, exp_out[f]);
         end
      end
   endtask

   task automatic test_load_store();
      idle(); D_addr = 8'h2A; D_wr = 1'b1; RF_Ra_addr = 4'd4;
      step();
      idle(); D_addr = 8'h2A;
      step();
      n_cmp++;
      if (Mem_q !== 16'hFFFF) begin
         n_err++; $display("FAIL load_a_mem_q: got %h expected ffff", Mem_q);
      end
      RF_s = 1'b1; RF_W_en = 1'b1; RF_W_addr = 4'd5; Alu_s0 = 3'd0;
      step();
      idle(); RF_Ra_addr = 4'd5;
      #1;
      n_cmp++;
      if (Ra_data !== 16'hFFFF) begin
         n_err++; $display("FAIL load_b_r5: got %h expected ffff", Ra_data);
      end
   endtask

   task automatic test_read_during_write();
      idle(); D_addr = 8'h10; D_wr = 1'b1; RF_Ra_addr = 4'd2;
      step();
      RF_Ra_addr = 4'd4;
      step();
      n_cmp++;
      if (Mem_q !== 16'h0002) begin
         n_err++; $display("FAIL rdw_old: got %h expected 0002", Mem_q);
      end
      D_wr = 1'b0;
      step();
      n_cmp++;
      if (Mem_q !== 16'hFFFF) begin
         n_err++; $display("FAIL rdw_new: got %h expected ffff", Mem_q);
      end
   endtask

   task automatic test_simultaneous();
      // R2 = R2 + 1 while R2 (pre-edge, 2) is stored at 0x50
      idle(); Alu_s0 = 3'd7; RF_Ra_addr = 4'd2; RF_W_en = 1'b1; RF_W_addr = 4'd2;
      D_addr = 8'h50; D_wr = 1'b1;
      step();
      idle(); RF_Ra_addr = 4'd2; D_addr = 8'h50;
      #1;
      n_cmp++;
      if (Ra_data !== 16'h0003) begin
         n_err++; $display("FAIL simul_rf: got %h expected 0003", Ra_data);
      end
      step();
      n_cmp++;
      if (Mem_q !== 16'h0002) begin
         n_err++; $display("FAIL simul_dm: got %h expected 0002", Mem_q);
      end
   endtask

   task automatic test_back_to_back();
      idle(); Alu_s0 = 3'd7; RF_Ra_addr = 4'd1; RF_W_en = 1'b1; RF_W_addr = 4'd1;
      #1;
      n_cmp++;
      if (Ra_data !== 16'h0001 || ALU_out !== 16'h0002) begin
         n_err++; $display("FAIL same_cycle_old: got a=%h alu=%h expected 0001/0002", Ra_data, ALU_out);
      end
      step();
      idle(); RF_Ra_addr = 4'd1;
      #1;
      n_cmp++;
      if (Ra_data !== 16'h0002) begin
         n_err++; $display("FAIL same_cycle_new: got %h expected 0002", Ra_data);
      end
      // reset lands on Load_B
      D_addr = 8'h2A;
      step();
      ResetN = 1'b0; RF_s = 1'b1; RF_W_en = 1'b1; RF_W_addr = 4'd5;
      step();
      ResetN = 1'b1; idle();
      n_cmp++;
      if (Mem_q !== 16'h0000) begin
         n_err++; $display("FAIL rst_load_mem_q: got %h expected 0000", Mem_q);
      end
      for (int i = 0; i < 16; i++) begin
         RF_Ra_addr = 4'(i);
         #1;
         n_cmp++;
         if (Ra_data !== 16'h0000) begin
            n_err++; $display("FAIL rst_load_rf[%0d]: got %h expected 0000", i, Ra_data);
         end
      end
   endtask

   initial begin
      ResetN = 1'b0; D_addr = '0; D_wr = 1'b0; RF_s = 1'b0; RF_W_en = 1'b0;
      RF_W_addr = '0; RF_Ra_addr = '0; RF_Rb_addr = '0; Alu_s0 = '0;
      test_reset();
      test_add_inc();
      test_sub_zero();
      test_load_store();
      test_read_during_write();
      test_simultaneous();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
